note_player: RTL and testbench

- Consumer end of the song_reader note interface.
- Latches each note/duration pair offered with a new_note pulse and times its duration in beats from an internal beat prescaler.
- Drives the current note and a load strobe to the downstream tone/frequency stage.
- Returns a one-cycle note_done pulse so song_reader advances to the next note; pauses while play is low.

---
 rtl/note_player.sv | 138 +++++++++++++
 tb/tb_note_player.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/note_player.sv
// ---------------------------------------------------------------------------
// note_player
//
// Consumer end of the song_reader note interface. Each note/duration pair
// offered with a new_note strobe is latched and then timed in beats. An
// internal prescaler divides clk down to beats. When the last beat of the
// note ends, a one-cycle note_done pulse tells song_reader to offer the next
// note. While play is low, all timing is frozen and the output is muted.
//
// Parameters:
//   BEAT_CYCLES - clk cycles per beat (>= 2)
//   PRESC_W     - prescaler width, 2**PRESC_W >= BEAT_CYCLES
//
// Ports:
//   clk           - system clock, rising edge
//   reset         - synchronous, active-high reset
//   play          - 1 = run, 0 = pause (timing frozen, output muted)
//   note          - note code from song_reader, 0 = rest
//   duration      - note length in beats
//   new_note      - one-cycle strobe, note/duration valid
//   note_done     - one-cycle pulse when the current note has finished
//   note_out      - latched note code, 0 while idle
//   load_new_note - one-cycle pulse in the cycle after a note is latched
//   note_active   - sound enable (playing, play high, note is not a rest)
//   beat          - one-cycle pulse at each beat boundary while playing
// ---------------------------------------------------------------------------
module note_player #(
    parameter int BEAT_CYCLES = 1000,
    parameter int PRESC_W     = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       play,
    input  logic [5:0] note,
    input  logic [5:0] duration,
    input  logic       new_note,
    output logic       note_done,
    output logic [5:0] note_out,
    output logic       load_new_note,
    output logic       note_active,
    output logic       beat
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PLAYING = 2'd1,
        DONE    = 2'd2
    } state_t;

    // Last prescaler value of a beat. It is truncated to the prescaler width.
    localparam logic [PRESC_W-1:0] BEAT_LAST = PRESC_W'(BEAT_CYCLES - 1);

    state_t             state_q, state_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [5:0]         beats_left_q, beats_left_d;
    logic [5:0]         note_q, note_d;
    logic               load_q, load_d;
    logic               beat_tick;

    // A beat boundary happens only while a note is actually running. It is
    // combinational, so it drops in the same cycle that play is released.
    assign beat_tick = (state_q == PLAYING) && play && (presc_q == BEAT_LAST);

    // Register stage for the FSM state, the beat timer and the latched note.
    // Reset throws away any note in progress. It raises no completion pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            presc_q      <= '0;
            beats_left_q <= '0;
            note_q       <= '0;
            load_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            presc_q      <= presc_d;
            beats_left_q <= beats_left_d;
            note_q       <= note_d;
            load_q       <= load_d;
        end
    end

    // Next-state logic. First the per-state behaviour runs. After that, a
    // new_note strobe overrides everything: it is accepted in any state,
    // whatever the value of play. In PLAYING this restarts the note without
    // a done pulse. In DONE it chains straight into the next note, with no
    // IDLE cycle in between. A zero duration goes straight to DONE.
    always_comb begin
        state_d      = state_q;
        presc_d      = presc_q;
        beats_left_d = beats_left_q;
        note_d       = note_q;
        load_d       = 1'b0;

        case (state_q)
            IDLE: begin
            end
            PLAYING: begin
                if (play) begin
                    if (beat_tick) begin
                        presc_d = '0;
                        // Guard keeps beats_left from wrapping below zero.
                        if (beats_left_q != 6'd0) begin
                            beats_left_d = beats_left_q - 6'd1;
                        end
                        if (beats_left_q == 6'd1) begin
                            state_d = DONE;
                        end
                    end else begin
                        presc_d = presc_q + PRESC_W'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                note_d  = '0;
            end
            default: begin
                state_d = IDLE;
                note_d  = '0;
            end
        endcase

        if (new_note) begin
            note_d       = note;
            beats_left_d = duration;
            presc_d      = '0;
            load_d       = 1'b1;
            state_d      = (duration != 6'd0) ? PLAYING : DONE;
        end
    end

    assign note_done     = (state_q == DONE);
    assign note_out      = note_q;
    assign load_new_note = load_q;
    assign note_active   = (state_q == PLAYING) && play && (note_q != 6'd0);
    assign beat          = beat_tick;

endmodule

// File: tb/tb_note_player.sv
// ---------------------------------------------------------------------------
// tb_note_player
//
// Self-checking bench for note_player with BEAT_CYCLES = 4. Each note that
// is issued pushes its expected latch cycle and its expected completion
// cycle into queues. Negedge monitors pop those entries and compare them
// whenever load_new_note or note_done is seen. Directed checks in the
// stimulus process cover reset, pause, rests, beats and reset mid-note.
// ---------------------------------------------------------------------------
module tb_note_player;

    localparam int BC = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       play;
    logic [5:0] note;
    logic [5:0] duration;
    logic       new_note;
    logic       note_done;
    logic [5:0] note_out;
    logic       load_new_note;
    logic       note_active;
    logic       beat;

    typedef struct {
        int         cycle;
        logic [5:0] val;
    } exp_t;

    exp_t doneQ[$];
    exp_t loadQ[$];

    int cyc      = 0;
    int checks   = 0;
    int failures = 0;
    int doneCnt  = 0;
    int beatCnt  = 0;

    note_player #(
        .BEAT_CYCLES(BC),
        .PRESC_W    (3)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .play         (play),
        .note         (note),
        .duration     (duration),
        .new_note     (new_note),
        .note_done    (note_done),
        .note_out     (note_out),
        .load_new_note(load_new_note),
        .note_active  (note_active),
        .beat         (beat)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Counts rising edges. After edge E, cyc == E.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: actual=%0d expected=%0d", name, actual, expected);
        end
    endtask

    // Monitor: compares every observed load or done pulse against the
    // oldest queued expectation, and counts beats and done pulses.
    always @(negedge clk) begin
        exp_t e;
        if (beat === 1'b1) beatCnt++;
        if (note_done === 1'b1) begin
            doneCnt++;
            if (doneQ.size() == 0) begin
                checkOutput("unexpected note_done cycle", cyc, -1);
            end else begin
                e = doneQ.pop_front();
                checkOutput("note_done cycle", cyc, e.cycle);
                checkOutput("note_out at done", int'(note_out), int'(e.val));
            end
        end
        if (load_new_note === 1'b1) begin
            if (loadQ.size() == 0) begin
                checkOutput("unexpected load_new_note cycle", cyc, -1);
            end else begin
                e = loadQ.pop_front();
                checkOutput("load_new_note cycle", cyc, e.cycle);
                checkOutput("note_out at load", int'(note_out), int'(e.val));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic waitCycles(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Offers one note for a single cycle. The latch edge is the next rising
    // edge, L. The load pulse is expected in cycle L. If the note is expected
    // to complete, note_done is expected in cycle L + d*BC + pause.
    task automatic applyStimulus(input logic [5:0] n, input logic [5:0] d,
                                 input int pause, input bit expectDone);
        exp_t e;
        note     = n;
        duration = d;
        new_note = 1'b1;
        e.cycle  = cyc + 1;
        e.val    = n;
        loadQ.push_back(e);
        if (expectDone) begin
            e.cycle = cyc + 1 + int'(d) * BC + pause;
            doneQ.push_back(e);
        end
        tick();
        new_note = 1'b0;
        note     = '0;
        duration = '0;
    endtask

    // Waits, with a cycle budget, until note_done is high. It also reports
    // whether note_active was seen high while waiting.
    task automatic waitDone(input int budget, output bit sawActive);
        sawActive = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (note_done === 1'b1) return;
            if (note_active === 1'b1) sawActive = 1'b1;
            tick();
        end
        checkOutput("note_done wait timeout", 0, 1);
    endtask

    initial begin
        bit sawAct;
        int b0;
        int d0;

        reset    = 1'b1;
        play     = 1'b0;
        note     = '0;
        duration = '0;
        new_note = 1'b0;

        // Reset, then idle.
        waitCycles(2);
        checkOutput("reset note_done", int'(note_done), 0);
        checkOutput("reset note_out", int'(note_out), 0);
        checkOutput("reset note_active", int'(note_active), 0);
        checkOutput("reset beat", int'(beat), 0);
        checkOutput("reset load_new_note", int'(load_new_note), 0);
        reset = 1'b0;
        play  = 1'b1;
        waitCycles(2);
        checkOutput("idle note_done", int'(note_done), 0);

        // Basic note: 20 for 3 beats.
        b0 = beatCnt;
        applyStimulus(6'd20, 6'd3, 0, 1'b1);
        checkOutput("basic note_out", int'(note_out), 20);
        checkOutput("basic note_active", int'(note_active), 1);
        waitDone(40, sawAct);
        checkOutput("basic beat count", beatCnt - b0, 3);
        tick();
        checkOutput("basic note_out cleared", int'(note_out), 0);
        checkOutput("basic note_done single", int'(note_done), 0);

        // Pause for 5 cycles in the middle of the note.
        b0 = beatCnt;
        applyStimulus(6'd20, 6'd3, 5, 1'b1);
        waitCycles(4);
        play = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            checkOutput("pause note_active", int'(note_active), 0);
            checkOutput("pause beat", int'(beat), 0);
            tick();
        end
        play = 1'b1;
        waitDone(40, sawAct);
        checkOutput("pause beat count", beatCnt - b0, 3);
        tick();

        // A rest of 2 beats, then a zero-duration note.
        applyStimulus(6'd0, 6'd2, 0, 1'b1);
        waitDone(40, sawAct);
        checkOutput("rest note_active", int'(sawAct), 0);
        tick();
        b0 = beatCnt;
        applyStimulus(6'd7, 6'd0, 0, 1'b1);
        checkOutput("zero-dur note_done", int'(note_done), 1);
        tick();
        checkOutput("zero-dur beat count", beatCnt - b0, 0);

        // Restart: note 9 is aborted by note 5. Then a new note is offered
        // in the DONE cycle of note 5.
        applyStimulus(6'd9, 6'd3, 0, 1'b0);
        waitCycles(5);
        applyStimulus(6'd5, 6'd4, 0, 1'b1);
        waitDone(80, sawAct);
        applyStimulus(6'd11, 6'd2, 0, 1'b1);
        checkOutput("direct switch note_out", int'(note_out), 11);
        checkOutput("direct switch note_done", int'(note_done), 0);
        waitDone(40, sawAct);
        tick();

        // Song-style loop: each note_done triggers the next note.
        d0 = doneCnt;
        for (int i = 0; i < 35; i++) begin
            applyStimulus(6'(i + 1), 6'((i % 4) + 1), 0, 1'b1);
            waitDone(40, sawAct);
            tick();
        end
        checkOutput("song done count", doneCnt - d0, 35);

        // Start a note, drop play, and check that no beats occur.
        applyStimulus(6'd13, 6'd4, 0, 1'b0);
        waitCycles(2);
        play = 1'b0;
        b0   = beatCnt;
        waitCycles(10);
        checkOutput("paused beat count", beatCnt - b0, 0);
        play = 1'b1;
        waitCycles(2);

        // Reset in the middle of the note.
        reset = 1'b1;
        tick();
        checkOutput("midreset note_done", int'(note_done), 0);
        checkOutput("midreset note_out", int'(note_out), 0);
        checkOutput("midreset note_active", int'(note_active), 0);
        checkOutput("midreset beat", int'(beat), 0);
        checkOutput("midreset load_new_note", int'(load_new_note), 0);
        reset = 1'b0;
        waitCycles(30);

        checkOutput("pending note_done entries", doneQ.size(), 0);
        checkOutput("pending load entries", loadQ.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
